// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive bit controller.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    EOP,
    ERR
  } rx_state_e;

  localparam logic [7:0]  SYNC_PATTERN   = 8'h80;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  // One serial CRC16 step; crc[15] is the x^15 term, data enters LSB-first.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Bit-timing recovery: line edge detector and phase counter producing the bit-centre strobe.
module usb_rx_bit_timer #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_line_i,
  input  logic en_i,
  output logic line_edge_c_o,
  output logic bit_strobe_o
);

  localparam int unsigned       PHASE_W   = $clog2(OVERSAMPLE);
  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PHASE_MID = PHASE_W'(OVERSAMPLE / 2 - 1);

  logic               d_line_q;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               strobe_q;

  assign line_edge_c_o = d_line_i ^ d_line_q;
  assign bit_strobe_o  = strobe_q;

  // Any line transition re-centres the bit; otherwise free-run one bit time per wrap.
  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
    if (line_edge_c_o) begin
      phase_d = '0;
    end else if (phase_q == PHASE_MAX) begin
      phase_d = '0;
    end
  end

  // Idle line is J (D+ high), so the edge detector resets to 1 to avoid a false start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_line_q <= 1'b1;
      phase_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      d_line_q <= d_line_i;
      phase_q  <= phase_d;
      strobe_q <= en_i && (phase_d == PHASE_MID);
    end
  end

endmodule

// File: rtl/usb_rx_bit_ctrl.sv
// USB full-speed receive bit controller: SYNC hunt, bit unstuffing, byte assembly, EOP/error detect.
// Defining USB_RX_CRC16_EN adds a CRC16 residual check on crc_ok_o; otherwise crc_ok_o is tied high.
module usb_rx_bit_ctrl #(
  parameter int unsigned OVERSAMPLE   = 8,
  parameter int unsigned SYNC_TIMEOUT = 16,
  parameter int unsigned STUFF_LIMIT  = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       d_line_i,
  input  logic       se0_i,
  input  logic       dec_bit_i,
  output logic       bit_strobe_o,
  output logic       rx_active_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       eop_o,
  output logic       rx_err_o,
  output logic       crc_ok_o
);

  import usb_rx_pkg::*;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned SYNC_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

  localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(STUFF_LIMIT);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_TIMEOUT - 1);

  rx_state_e           state_q, state_d;
  logic [BYTE_W-1:0]   win_q, win_d;
  logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                eop_q, eop_d;
  logic                rx_err_q, rx_err_d;
  logic                rx_active_q, rx_active_d;
  logic                se0_seen_q, se0_seen_d;
  logic                strobe;
  logic                line_edge_c;

  usb_rx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .d_line_i      (d_line_i),
    .en_i          (state_d != IDLE),
    .line_edge_c_o (line_edge_c),
    .bit_strobe_o  (strobe)
  );

  assign bit_strobe_o = strobe;
  assign rx_active_o  = rx_active_q;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign eop_o        = eop_q;
  assign rx_err_o     = rx_err_q;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    sync_cnt_d  = sync_cnt_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    eop_d       = 1'b0;
    rx_err_d    = 1'b0;
    rx_active_d = rx_active_q;
    se0_seen_d  = se0_seen_q;

    unique case (state_q)
      IDLE: begin
        win_d      = '0;
        sync_cnt_d = '0;
        bit_cnt_d  = '0;
        ones_d     = '0;
        se0_seen_d = 1'b0;
        if (line_edge_c && !se0_i) begin
          state_d = SYNC;
        end
      end

      SYNC: begin
        if (strobe) begin
          win_d      = {dec_bit_i, win_q[BYTE_W-1:1]};
          sync_cnt_d = sync_cnt_q + SYNC_W'(1);
          if (se0_i) begin
            state_d = IDLE;
          end else if (win_d == SYNC_PATTERN) begin
            // The trailing SYNC 1 counts toward the first stuffing run.
            state_d     = DATA;
            rx_active_d = 1'b1;
            ones_d      = ONES_W'(1);
            bit_cnt_d   = '0;
          end else if (sync_cnt_q == SYNC_LAST) begin
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (strobe) begin
          if (se0_i) begin
            state_d = EOP;
          end else if (ones_q == ONES_MAX) begin
            if (dec_bit_i) begin
              state_d  = ERR;
              rx_err_d = 1'b1;
            end else begin
              ones_d = '0;
            end
          end else begin
            ones_d    = dec_bit_i ? (ones_q + ONES_W'(1)) : '0;
            shift_d   = {dec_bit_i, shift_q[BYTE_W-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              rx_data_d  = shift_d;
              rx_valid_d = 1'b1;
            end
          end
        end
      end

      EOP: begin
        if (strobe && !se0_i) begin
          eop_d       = 1'b1;
          rx_err_d    = (bit_cnt_q != '0);
          rx_active_d = 1'b0;
          state_d     = IDLE;
        end
      end

      ERR: begin
        // Hold rx_active until the sender's SE0 has come and gone.
        if (strobe) begin
          if (se0_i) begin
            se0_seen_d = 1'b1;
          end else if (se0_seen_q) begin
            rx_active_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      win_q       <= '0;
      sync_cnt_q  <= '0;
      ones_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      eop_q       <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_active_q <= 1'b0;
      se0_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      sync_cnt_q  <= sync_cnt_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      eop_q       <= eop_d;
      rx_err_q    <= rx_err_d;
      rx_active_q <= rx_active_d;
      se0_seen_q  <= se0_seen_d;
    end
  end

`ifdef USB_RX_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_ok_q, crc_ok_d;
  logic        sync_match_c;
  logic        data_bit_c;

  assign sync_match_c = (state_q == SYNC) && strobe && !se0_i &&
                        ({dec_bit_i, win_q[BYTE_W-1:1]} == SYNC_PATTERN);
  assign data_bit_c   = (state_q == DATA) && strobe && !se0_i && (ones_q != ONES_MAX);
  assign crc_ok_o     = crc_ok_q;

  // CRC covers every non-stuffed data bit; the verdict is latched at packet end.
  always_comb begin
    crc_d    = crc_q;
    crc_ok_d = crc_ok_q;
    if (sync_match_c) begin
      crc_d    = CRC16_INIT;
      crc_ok_d = 1'b0;
    end else if (data_bit_c) begin
      crc_d = crc16_step(crc_q, dec_bit_i);
    end
    if (eop_d) begin
      crc_ok_d = (crc_q == CRC16_RESIDUAL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q    <= CRC16_INIT;
      crc_ok_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_ok_q <= crc_ok_d;
    end
  end
`else
  assign crc_ok_o = 1'b1;
`endif

endmodule

// File: tb/tb_usb_rx_bit_ctrl.sv
// Directed bench for usb_rx_bit_ctrl with a behavioural NRZI line encoder and decoder.
module tb_usb_rx_bit_ctrl;

  localparam int OS = 8;
`ifdef USB_RX_CRC16_EN
  localparam logic EXP_CRC_RST = 1'b0;
`else
  localparam logic EXP_CRC_RST = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       d_line;
  logic       se0;
  logic       dec_bit;
  logic       bit_strobe;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       eop;
  logic       rx_err;
  logic       crc_ok;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  usb_rx_bit_ctrl #(
    .OVERSAMPLE   (OS),
    .SYNC_TIMEOUT (16),
    .STUFF_LIMIT  (6)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .d_line_i     (d_line),
    .se0_i        (se0),
    .dec_bit_i    (dec_bit),
    .bit_strobe_o (bit_strobe),
    .rx_active_o  (rx_active),
    .rx_data_o    (rx_data),
    .rx_valid_o   (rx_valid),
    .eop_o        (eop),
    .rx_err_o     (rx_err),
    .crc_ok_o     (crc_ok)
  );

  // NRZI decoder model clocked by the DUT strobe: no transition decodes as 1.
  logic last_level;
  assign dec_bit = (d_line == last_level);
  always @(posedge clk) begin
    if (rst) last_level <= 1'b1;
    else if (bit_strobe) last_level <= d_line;
  end

  // Output monitor sampled on the falling edge.
  int   valid_cnt = 0, eop_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   clash_cnt = 0, lat_bad = 0, strobe_cnt = 0;
  logic [7:0] data_log [0:63];
  logic prev_strobe = 1'b0;
  logic last_crc_ok = 1'b0;
  always @(negedge clk) begin
    prev_strobe <= bit_strobe;
    if (bit_strobe) strobe_cnt <= strobe_cnt + 1;
    if (rx_valid) begin
      if (valid_cnt < 64) data_log[valid_cnt] <= rx_data;
      valid_cnt <= valid_cnt + 1;
      if (!prev_strobe) lat_bad <= lat_bad + 1;
    end
    if (eop) begin
      eop_cnt     <= eop_cnt + 1;
      last_crc_ok <= crc_ok;
    end
    if (rx_err) err_cnt <= err_cnt + 1;
    if (eop && rx_err) both_cnt <= both_cnt + 1;
    if (eop && rx_valid) clash_cnt <= clash_cnt + 1;
  end

  // Line encoder state: current line level and the transmitter's ones run.
  logic cur  = 1'b1;
  int   ones = 0;

  task automatic hold(input logic lvl, input logic s0, input int n);
    d_line = lvl;
    se0    = s0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic nrzi(input logic b, input int n);
    if (!b) cur = ~cur;
    hold(cur, 1'b0, n);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 8; i++) nrzi(i == 7, OS);
    ones = 1;
  endtask

  task automatic send_dbit(input logic b, input int n);
    nrzi(b, n);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      nrzi(1'b0, OS);
      ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit jitter);
    for (int i = 0; i < 8; i++)
      send_dbit(v[i], jitter ? ((i % 2 == 1) ? OS + 1 : OS - 1) : OS);
  endtask

  task automatic send_eop();
    hold(1'b0, 1'b1, 2 * OS);
    cur = 1'b1;
    hold(1'b1, 1'b0, OS);
    hold(1'b1, 1'b0, 2 * OS);
  endtask

  task automatic test_reset();
    int s0;
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL reset_rx_active got=%b exp=0", rx_active); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (eop !== 1'b0 || rx_err !== 1'b0) begin failures++; $display("FAIL reset_eop_err got=%b%b exp=00", eop, rx_err); end
    checks++; if (bit_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", bit_strobe); end
    checks++; if (crc_ok !== EXP_CRC_RST) begin failures++; $display("FAIL reset_crc_ok got=%b exp=%b", crc_ok, EXP_CRC_RST); end
    rst = 1'b0;
    s0 = strobe_cnt;
    hold(1'b1, 1'b0, 5 * OS);
    checks++; if (strobe_cnt != s0) begin failures++; $display("FAIL idle_no_strobe got=%0d exp=0", strobe_cnt - s0); end
  endtask

  task automatic test_basic();
    int v0, e0, r0;
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    for (int i = 0; i < 7; i++) nrzi(1'b0, OS);
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL sync7_rx_active got=%b exp=0", rx_active); end
    nrzi(1'b1, OS);
    ones = 1;
    checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL sync8_rx_active got=%b exp=1", rx_active); end
    send_byte(8'hA5, 1'b0);
    send_eop();
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL a5_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data_log[v0] !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", data_log[v0]); end
    checks++; if (eop_cnt - e0 != 1) begin failures++; $display("FAIL a5_eop_count got=%0d exp=1", eop_cnt - e0); end
    checks++; if (err_cnt != r0) begin failures++; $display("FAIL a5_err_count got=%0d exp=0", err_cnt - r0); end
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL a5_rx_active_end got=%b exp=0", rx_active); end
  endtask

  task automatic test_stuffing();
    int v0, e0, r0;
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    send_sync();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h7F, 1'b0);
    send_eop();
    checks++; if (valid_cnt - v0 != 2) begin failures++; $display("FAIL stuff_valid_count got=%0d exp=2", valid_cnt - v0); end
    checks++; if (data_log[v0] !== 8'hFF) begin failures++; $display("FAIL stuff_byte0 got=%h exp=ff", data_log[v0]); end
    checks++; if (data_log[v0+1] !== 8'h7F) begin failures++; $display("FAIL stuff_byte1 got=%h exp=7f", data_log[v0+1]); end
    checks++; if (err_cnt != r0 || eop_cnt - e0 != 1) begin failures++; $display("FAIL stuff_err_eop got=%0d/%0d exp=0/1", err_cnt - r0, eop_cnt - e0); end
  endtask

  task automatic test_stuff_error();
    int v0, e0, r0;
    v0 = valid_cnt; e0 = eop_cnt; r0 = err_cnt;
    send_sync();
    for (int i = 0; i < 7; i++) nrzi(1'b1, OS);
    checks++; if (err_cnt - r0 != 1) begin failures++; $display("FAIL stufferr_err_count got=%0d exp=1", err_cnt - r0); end
    hold(1'b0, 1'b1, 2 * OS);
    checks++; if (rx_active !== 1'b1) begin failures++; $display("FAIL stufferr_active_in_se0 got=%b exp=1", rx_active); end
    cur = 1'b1;
    hold(1'b1, 1'b0, OS);
    hold(1'b1, 1'b0, 2 * OS);
    checks++; if (rx_active !== 1'b0) begin failures++; $display("FAIL stufferr_active_after_j got=%b exp=0", rx_active); end
    checks++; if (eop_cnt != e0) begin failures++; $display("FAIL stufferr_eop_count got=%0d exp=0", eop_cnt - e0); end
    checks++; if (err_cnt - r0 != 1 || valid_cnt != v0) begin failures++; $display("FAIL stufferr_err_valid got=%0d/%0d exp=1/0", err_cnt - r0, valid_cnt - v0); end
  endtask

  task automatic test_partial_byte();
    int v0, e0, b0;
    v0 = valid_cnt; e0 = eop_cnt; b0 = both_cnt;
    send_sync();
    send_dbit(1'b1, OS);
    send_dbit(1'b0, OS);
    send_dbit(1'b1, OS);
    send_eop();
    checks++; if (eop_cnt - e0 != 1) begin failures++; $display("FAIL partial_eop_count got=%0d exp=1", eop_cnt - e0); end
    checks++; if (both_cnt - b0 != 1) begin failures++; $display("FAIL partial_eop_with_err got=%0d exp=1", both_cnt - b0); end
    checks++; if (valid_cnt != v0) begin failures++; $display("FAIL partial_valid_count got=%0d exp=0", valid_cnt - v0); end
  endtask

  task automatic test_jitter();
    int v0, r0;
    v0 = valid_cnt; r0 = err_cnt;
    send_sync();
    send_byte(8'h3C, 1'b1);
    send_eop();
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("FAIL jitter_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (data_log[v0] !== 8'h3C) begin failures++; $display("FAIL jitter_data got=%h exp=3c", data_log[v0]); end
    checks++; if (err_cnt != r0) begin failures++; $display("FAIL jitter_err_count got=%0d exp=0", err_cnt - r0); end
  endtask

`ifdef USB_RX_CRC16_EN
  function automatic logic [15:0] tb_crc(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] c;
    logic [15:0] msg;
    logic fb;
    c = 16'hFFFF;
    msg = {b1, b0};
    for (int i = 0; i < 16; i++) begin
      fb = c[15] ^ msg[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return c;
  endfunction

  task automatic send_crc_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] crc);
    send_sync();
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    for (int i = 15; i >= 0; i--) send_dbit(~crc[i], OS);
    send_eop();
  endtask

  task automatic test_crc();
    logic [15:0] c;
    c = tb_crc(8'h00, 8'h01);
    send_crc_packet(8'h00, 8'h01, c);
    checks++; if (last_crc_ok !== 1'b1) begin failures++; $display("FAIL crc_good got=%b exp=1", last_crc_ok); end
    checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL crc_good_hold got=%b exp=1", crc_ok); end
    send_crc_packet(8'h00, 8'h03, c);
    checks++; if (last_crc_ok !== 1'b0) begin failures++; $display("FAIL crc_bad got=%b exp=0", last_crc_ok); end
  endtask
`endif

  task automatic test_reset_mid();
    int e0, r0, s0;
    e0 = eop_cnt; r0 = err_cnt;
    send_sync();
    send_dbit(1'b1, OS);
    send_dbit(1'b0, OS);
    send_dbit(1'b1, OS);
    d_line = ~cur;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    d_line = 1'b1;
    se0 = 1'b0;
    cur = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rx_active !== 1'b0 || rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_active_valid got=%b%b exp=00", rx_active, rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data got=%h exp=00", rx_data); end
    checks++; if (eop !== 1'b0 || rx_err !== 1'b0 || bit_strobe !== 1'b0) begin failures++; $display("FAIL midrst_pulses got=%b%b%b exp=000", eop, rx_err, bit_strobe); end
    checks++; if (crc_ok !== EXP_CRC_RST) begin failures++; $display("FAIL midrst_crc_ok got=%b exp=%b", crc_ok, EXP_CRC_RST); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    s0 = strobe_cnt;
    hold(1'b1, 1'b0, 4 * OS);
    checks++; if (eop_cnt != e0 || err_cnt != r0) begin failures++; $display("FAIL midrst_no_eop_err got=%0d/%0d exp=0/0", eop_cnt - e0, err_cnt - r0); end
    checks++; if (rx_active !== 1'b0 || strobe_cnt != s0) begin failures++; $display("FAIL midrst_stays_idle got=%b/%0d exp=0/0", rx_active, strobe_cnt - s0); end
  endtask

  initial begin
    rst = 1'b1;
    d_line = 1'b1;
    se0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stuffing();
    test_stuff_error();
    test_partial_byte();
    test_jitter();
`ifdef USB_RX_CRC16_EN
    test_crc();
`endif
    test_reset_mid();
    checks++; if (lat_bad != 0) begin failures++; $display("FAIL valid_latency got=%0d exp=0", lat_bad); end
    checks++; if (clash_cnt != 0) begin failures++; $display("FAIL valid_eop_same_cycle got=%0d exp=0", clash_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
